// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 16-register CPU front end.
// Provides data/register widths, the NOP encoding, the default reset PC,
// and the packed layouts of the IF/ID and ID/EX pipeline registers
// together with their empty/bubble values.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [DATA_W-1:0] NOP_INSTR        = 16'h0000;
    localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic              valid;
    } ifid_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  valid;
        logic [DATA_W-1:0]     rs1_val;
        logic [DATA_W-1:0]     rs2_val;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc;
    } idex_t;

    // IF/ID with no real instruction: NOP at PC 0, not valid.
    localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

    // A bubble is all-zero: rd=0 and no write/memory enables, so it has
    // no architectural side effect downstream.
    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/frontend_pipe_regs_pipe_reg.sv
// pipe_reg_en_flush: generic pipeline register with load enable and flush.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, loads RST_VAL
//   en        1: load d
//   flush     1: load flush_val (takes priority over en)
//   flush_val value loaded on flush
//   d         next value when enabled
//   q         registered output
module pipe_reg_en_flush #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] flush_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (flush) begin
            q <= flush_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/frontend_pipe_regs.sv
// frontend_pipe_regs: PC, IF/ID and ID/EX registers of the CPU front end.
// Consumes the hazard detector's strobes and EX-stage branch redirects,
// and counts stall cycles for performance debug.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_write/ifid_write/idex_flush hazard strobes
//   branch_taken, branch_target   EX redirect
//   imem_rdata                    instruction at pc (combinational imem)
//   id_*                          decoded fields from the ID stage
//   pc                            fetch address
//   ifid_instr/ifid_pc/ifid_valid IF/ID register
//   idex_*                        ID/EX register
//   stall_cnt                     saturating stall-cycle counter
//
// Strobe semantics: these are level controls sampled at every posedge, not
// a valid/ready handshake. pc_write=0 holds the PC, ifid_write=0 holds
// IF/ID, idex_flush=1 loads a bubble into ID/EX. branch_taken overrides all
// three for that cycle, and rst overrides everything.
module frontend_pipe_regs
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [15:0] PC_STEP  = 16'd1,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             ifid_write,
    input  logic             idex_flush,
    input  logic             branch_taken,
    input  logic [15:0]      branch_target,
    input  logic [15:0]      imem_rdata,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic [3:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [15:0]      id_rs1_val,
    input  logic [15:0]      id_rs2_val,
    input  logic [15:0]      id_imm,
    output logic [15:0]      pc,
    output logic [15:0]      ifid_instr,
    output logic [15:0]      ifid_pc,
    output logic             ifid_valid,
    output logic [3:0]       idex_rs1,
    output logic [3:0]       idex_rs2,
    output logic [3:0]       idex_rd,
    output logic             idex_reg_write,
    output logic             idex_mem_read,
    output logic             idex_mem_write,
    output logic             idex_valid,
    output logic [15:0]      idex_rs1_val,
    output logic [15:0]      idex_rs2_val,
    output logic [15:0]      idex_imm,
    output logic [15:0]      idex_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    ifid_t ifid_d, ifid_q;
    idex_t idex_d, idex_q;

    // PC: redirect beats the hazard hold; the add wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_target;
        end else if (pc_write) begin
            pc <= pc + PC_STEP;
        end
    end

    // A redirect cycle is not counted as a stall even though pc_write may be 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!branch_taken && !pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        ifid_d       = IFID_EMPTY;
        ifid_d.instr = imem_rdata;
        ifid_d.pc    = pc;
        ifid_d.valid = 1'b1;
    end

    always_comb begin
        idex_d           = IDEX_BUBBLE;
        idex_d.rs1       = id_rs1;
        idex_d.rs2       = id_rs2;
        idex_d.rd        = id_rd;
        idex_d.reg_write = id_reg_write;
        idex_d.mem_read  = id_mem_read;
        idex_d.mem_write = id_mem_write;
        idex_d.valid     = ifid_q.valid;
        idex_d.rs1_val   = id_rs1_val;
        idex_d.rs2_val   = id_rs2_val;
        idex_d.imm       = id_imm;
        idex_d.pc        = ifid_q.pc;
    end

    pipe_reg_en_flush #(
        .W       ($bits(ifid_t)),
        .RST_VAL (IFID_EMPTY)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .en        (ifid_write),
        .flush     (branch_taken),
        .flush_val (IFID_EMPTY),
        .d         (ifid_d),
        .q         (ifid_q)
    );

    // ID/EX reloads every cycle; only a flush or redirect substitutes a bubble.
    pipe_reg_en_flush #(
        .W       ($bits(idex_t)),
        .RST_VAL (IDEX_BUBBLE)
    ) u_idex (
        .clk       (clk),
        .rst       (rst),
        .en        (1'b1),
        .flush     (branch_taken | idex_flush),
        .flush_val (IDEX_BUBBLE),
        .d         (idex_d),
        .q         (idex_q)
    );

    assign ifid_instr     = ifid_q.instr;
    assign ifid_pc        = ifid_q.pc;
    assign ifid_valid     = ifid_q.valid;
    assign idex_rs1       = idex_q.rs1;
    assign idex_rs2       = idex_q.rs2;
    assign idex_rd        = idex_q.rd;
    assign idex_reg_write = idex_q.reg_write;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_mem_write = idex_q.mem_write;
    assign idex_valid     = idex_q.valid;
    assign idex_rs1_val   = idex_q.rs1_val;
    assign idex_rs2_val   = idex_q.rs2_val;
    assign idex_imm       = idex_q.imm;
    assign idex_pc        = idex_q.pc;

endmodule

// File: tb/tb_frontend_pipe_regs.sv
// Testbench for frontend_pipe_regs: a default instance, one with
// RESET_PC=16'hFFFF (wrap) and one with CNT_W=3 (saturation), all driven
// by the same stimulus and compared against a behavioural model.
module tb_frontend_pipe_regs;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        pc_write = 1'b0, ifid_write = 1'b0, idex_flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] imem_rdata;
    logic [3:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic [15:0] id_rs1_val = '0, id_rs2_val = '0, id_imm = '0;

    // main instance outputs
    logic [15:0] pc, ifid_instr, ifid_pc, idex_rs1_val, idex_rs2_val, idex_imm, idex_pc;
    logic        ifid_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_valid;
    logic [3:0]  idex_rs1, idex_rs2, idex_rd;
    logic [15:0] stall_cnt;

    // wrap instance outputs
    logic [15:0] w_pc, w_ifid_instr, w_ifid_pc, w_idex_rs1_val, w_idex_rs2_val, w_idex_imm, w_idex_pc;
    logic        w_ifid_valid, w_idex_reg_write, w_idex_mem_read, w_idex_mem_write, w_idex_valid;
    logic [3:0]  w_idex_rs1, w_idex_rs2, w_idex_rd;
    logic [15:0] w_stall_cnt;

    // saturation instance outputs
    logic [15:0] s_pc, s_ifid_instr, s_ifid_pc, s_idex_rs1_val, s_idex_rs2_val, s_idex_imm, s_idex_pc;
    logic        s_ifid_valid, s_idex_reg_write, s_idex_mem_read, s_idex_mem_write, s_idex_valid;
    logic [3:0]  s_idex_rs1, s_idex_rs2, s_idex_rd;
    logic [2:0]  s_stall_cnt;

    // Combinational instruction memory, answering the main instance's pc.
    assign imem_rdata = 16'hA000 + pc;

    frontend_pipe_regs dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_flush(idex_flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rdata(imem_rdata), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_valid(idex_valid),
        .idex_rs1_val(idex_rs1_val), .idex_rs2_val(idex_rs2_val), .idex_imm(idex_imm),
        .idex_pc(idex_pc), .stall_cnt(stall_cnt)
    );

    frontend_pipe_regs #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_flush(idex_flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rdata(imem_rdata), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .pc(w_pc), .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc), .ifid_valid(w_ifid_valid),
        .idex_rs1(w_idex_rs1), .idex_rs2(w_idex_rs2), .idex_rd(w_idex_rd),
        .idex_reg_write(w_idex_reg_write), .idex_mem_read(w_idex_mem_read),
        .idex_mem_write(w_idex_mem_write), .idex_valid(w_idex_valid),
        .idex_rs1_val(w_idex_rs1_val), .idex_rs2_val(w_idex_rs2_val), .idex_imm(w_idex_imm),
        .idex_pc(w_idex_pc), .stall_cnt(w_stall_cnt)
    );

    frontend_pipe_regs #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_flush(idex_flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rdata(imem_rdata), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .pc(s_pc), .ifid_instr(s_ifid_instr), .ifid_pc(s_ifid_pc), .ifid_valid(s_ifid_valid),
        .idex_rs1(s_idex_rs1), .idex_rs2(s_idex_rs2), .idex_rd(s_idex_rd),
        .idex_reg_write(s_idex_reg_write), .idex_mem_read(s_idex_mem_read),
        .idex_mem_write(s_idex_mem_write), .idex_valid(s_idex_valid),
        .idex_rs1_val(s_idex_rs1_val), .idex_rs2_val(s_idex_rs2_val), .idex_imm(s_idex_imm),
        .idex_pc(s_idex_pc), .stall_cnt(s_stall_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];   // expected fetch PC after each cycle

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: fetch address, the instruction sitting in decode,
    // the operation handed to execute, and the stall tallies.
    logic [15:0] m_pc, m_w_pc;
    logic [15:0] m_if_instr, m_if_pc;
    logic        m_if_valid;
    logic [79:0] m_ex;          // {rs1,rs2,rd,rw,mr,mw,valid,rs1v,rs2v,imm,pc}
    int          m_cnt, m_s_cnt;

    task automatic model_step();
        if (rst) begin
            m_pc = 16'h0000; m_w_pc = 16'hFFFF;
            m_if_instr = 16'h0000; m_if_pc = 16'h0000; m_if_valid = 1'b0;
            m_ex = '0; m_cnt = 0; m_s_cnt = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_w_pc = branch_target;
            m_if_instr = 16'h0000; m_if_pc = 16'h0000; m_if_valid = 1'b0;
            m_ex = '0;
        end else begin
            // Execute receives what decode held before this edge.
            if (idex_flush) m_ex = '0;
            else m_ex = {id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_mem_write,
                         m_if_valid, id_rs1_val, id_rs2_val, id_imm, m_if_pc};
            if (ifid_write) begin
                m_if_instr = 16'hA000 + m_pc;
                m_if_pc    = m_pc;
                m_if_valid = 1'b1;
            end
            if (pc_write) begin
                m_pc   = 16'((32'(m_pc) + 1) % 65536);
                m_w_pc = 16'((32'(m_w_pc) + 1) % 65536);
            end else begin
                if (m_cnt < 65535) m_cnt++;
                if (m_s_cnt < 7) m_s_cnt++;
            end
        end
        exp_q.push_back(m_pc);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic pw, input logic iw, input logic fl,
                        input logic bt, input logic [15:0] tgt);
        rst = r; pc_write = pw; ifid_write = iw; idex_flush = fl;
        branch_taken = bt; branch_target = tgt;
        id_rs1 = 4'($urandom_range(0, 15)); id_rs2 = 4'($urandom_range(0, 15));
        id_rd = 4'($urandom_range(1, 15));
        id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = 1'($urandom_range(0, 1));
        id_mem_write = 1'($urandom_range(0, 1));
        id_rs1_val = 16'($urandom); id_rs2_val = 16'($urandom); id_imm = 16'($urandom);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("pc", 80'(pc), 80'(exp_q.pop_front()));
        check("ifid_instr", 80'(ifid_instr), 80'(m_if_instr));
        check("ifid_pc", 80'(ifid_pc), 80'(m_if_pc));
        check("ifid_valid", 80'(ifid_valid), 80'(m_if_valid));
        check("idex", {idex_rs1, idex_rs2, idex_rd, idex_reg_write, idex_mem_read,
                       idex_mem_write, idex_valid, idex_rs1_val, idex_rs2_val,
                       idex_imm, idex_pc}, m_ex);
        check("stall_cnt", 80'(stall_cnt), 80'(m_cnt));
        check("wrap_pc", 80'(w_pc), 80'(m_w_pc));
        check("sat_cnt", 80'(s_stall_cnt), 80'(m_s_cnt));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        @(negedge clk);

        // Reset for two cycles with random strobes.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        check("rst_pc", 80'(pc), 80'(16'h0000));
        check("rst_ifid_valid", 80'(ifid_valid), 80'(1'b0));
        check("rst_idex_valid", 80'(idex_valid), 80'(1'b0));
        check("rst_cnt", 80'(stall_cnt), 80'(16'd0));
        check("rst_wrap_pc", 80'(w_pc), 80'(16'hFFFF));

        // Free run.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("wrap_to_zero", 80'(w_pc), 80'(16'h0000));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("fr_pc", 80'(pc), 80'(16'd4));
        check("fr_instr", 80'(ifid_instr), 80'(16'hA003));
        check("fr_ifid_pc", 80'(ifid_pc), 80'(16'd3));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

        // Load-use stall at pc=5.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        check("stall_pc", 80'(pc), 80'(16'd5));
        check("stall_ifid", 80'(ifid_instr), 80'(16'hA004));
        check("stall_idex_valid", 80'(idex_valid), 80'(1'b0));
        check("stall_idex_rd", 80'(idex_rd), 80'(4'd0));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("post_stall_idex_pc", 80'(idex_pc), 80'(16'd4));
        check("post_stall_idex_valid", 80'(idex_valid), 80'(1'b1));
        check("post_stall_cnt", 80'(stall_cnt), 80'(16'd1));

        // Branch during a stall.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
        check("br_pc", 80'(pc), 80'(16'h0040));
        check("br_ifid_valid", 80'(ifid_valid), 80'(1'b0));
        check("br_idex_valid", 80'(idex_valid), 80'(1'b0));
        check("br_cnt", 80'(stall_cnt), 80'(16'd1));

        // Hold pc_write low for 10 cycles.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("sat_cnt_7", 80'(s_stall_cnt), 80'(3'd7));
        check("cnt_11", 80'(stall_cnt), 80'(16'd11));

        // Random strobe mix with occasional redirects and resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
